// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core with a req/ack memory bus, precise traps into a
// sticky HALT state, a retire strobe and a combinational debug register port.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] SP_INIT   = 32'h0000_0FFC,
    parameter logic [31:0] GP_INIT   = 32'h0000_0800,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam int AW = $clog2(REG_COUNT);
    localparam logic [5:0] RC = 6'(REG_COUNT);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t      state;
    logic [31:0] pc, inst, ea;
    logic [31:0] rf [REG_COUNT];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign pc_plus4 = pc + 32'd4;

    // Out-of-range indices read as zero; decode traps them before any use.
    assign rs1_val   = (rs1 != 5'd0 && {1'b0, rs1} < RC) ? rf[rs1[AW-1:0]] : 32'h0;
    assign rs2_val   = (rs2 != 5'd0 && {1'b0, rs2} < RC) ? rf[rs2[AW-1:0]] : 32'h0;
    assign dbg_rdata = (dbg_raddr != 5'd0 && {1'b0, dbg_raddr} < RC) ? rf[dbg_raddr[AW-1:0]] : 32'h0;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic alt);
        logic [31:0] r;
        case (f)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'h0, $signed(a) < $signed(b)};
            3'd3:    r = {31'h0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic        legal, use_rd, use_rs1, use_rs2, is_ld, is_st, sys_trap, wr, jump, br_take, misal;
    logic [31:0] res, npc, addr_ea;
    logic [1:0]  trap;

    always_comb begin
        case (funct3)
            3'd0:    br_take = rs1_val == rs2_val;
            3'd1:    br_take = rs1_val != rs2_val;
            3'd4:    br_take = $signed(rs1_val) <  $signed(rs2_val);
            3'd5:    br_take = $signed(rs1_val) >= $signed(rs2_val);
            3'd6:    br_take = rs1_val <  rs2_val;
            default: br_take = rs1_val >= rs2_val;
        endcase
    end

    always_comb begin
        legal    = 1'b1;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        sys_trap = 1'b0;
        wr       = 1'b0;
        jump     = 1'b0;
        res      = 32'h0;
        npc      = pc_plus4;
        addr_ea  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
        case (opcode)
            OP_LUI: begin
                use_rd = 1'b1; wr = 1'b1; res = imm_u;
            end
            OP_AUIPC: begin
                use_rd = 1'b1; wr = 1'b1; res = pc + imm_u;
            end
            OP_JAL: begin
                use_rd = 1'b1; wr = 1'b1; res = pc_plus4;
                npc = pc + imm_j; jump = 1'b1;
            end
            OP_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1; res = pc_plus4;
                legal = funct3 == 3'd0;
                npc = (rs1_val + imm_i) & ~32'h1; jump = 1'b1;
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                legal = funct3 != 3'd2 && funct3 != 3'd3;
                if (br_take) begin
                    npc = pc + imm_b; jump = 1'b1;
                end
            end
            OP_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; is_ld = 1'b1;
                legal = funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7;
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_st = 1'b1;
                legal = funct3 <= 3'd2;
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
                if (funct3 == 3'd1) legal = funct7 == 7'h00;
                if (funct3 == 3'd5) legal = funct7 == 7'h00 || funct7 == 7'h20;
                res = alu(rs1_val, imm_i, funct3, funct3 == 3'd5 && inst[30]);
            end
            OP_REG: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr = 1'b1;
                legal = funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
                res = alu(rs1_val, rs2_val, funct3, inst[30]);
            end
            OP_FENCE: legal = funct3 == 3'd0;
            OP_SYS: begin
                if (inst == 32'h0000_0073 || inst == 32'h0010_0073) sys_trap = 1'b1;
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (use_rd  && {1'b0, rd}  >= RC) legal = 1'b0;
        if (use_rs1 && {1'b0, rs1} >= RC) legal = 1'b0;
        if (use_rs2 && {1'b0, rs2} >= RC) legal = 1'b0;
    end

    always_comb begin
        misal = jump && npc[1:0] != 2'b00;
        if ((is_ld || is_st) && funct3[1:0] == 2'd1 && addr_ea[0]) misal = 1'b1;
        if ((is_ld || is_st) && funct3[1:0] == 2'd2 && addr_ea[1:0] != 2'b00) misal = 1'b1;
        trap = !legal ? 2'd1 : sys_trap ? 2'd3 : misal ? 2'd2 : 2'd0;
    end

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;
    assign ld_b = mem_rdata[{ea[1:0], 3'b000} +: 8];
    assign ld_h = ea[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (funct3)
            3'd0:    ld_val = {{24{ld_b[7]}}, ld_b};
            3'd1:    ld_val = {{16{ld_h[15]}}, ld_h};
            3'd4:    ld_val = {24'h0, ld_b};
            3'd5:    ld_val = {16'h0, ld_h};
            default: ld_val = mem_rdata;
        endcase
    end

    // Bus outputs come only from state, pc, inst, ea and the (frozen) register file,
    // so they stay stable for the whole request.
    logic [3:0] st_strb;
    always_comb begin
        case (funct3[1:0])
            2'd0:    st_strb = 4'b0001 << ea[1:0];
            2'd1:    st_strb = ea[1] ? 4'b1100 : 4'b0011;
            default: st_strb = 4'b1111;
        endcase
        case (funct3[1:0])
            2'd0:    mem_wdata = {4{rs2_val[7:0]}};
            2'd1:    mem_wdata = {2{rs2_val[15:0]}};
            default: mem_wdata = rs2_val;
        endcase
    end

    assign mem_req   = !rst && (state == FETCH || state == MEM);
    assign mem_we    = state == MEM && opcode == OP_STORE;
    assign mem_addr  = (state == MEM) ? ea : pc;
    assign mem_wstrb = mem_we ? st_strb : 4'b0000;
    assign retire    = !rst && ((state == EXEC && trap == 2'd0 && !is_ld && !is_st) ||
                                (state == MEM && mem_ack));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            ea         <= 32'h0;
            halted     <= 1'b0;
            trap_cause <= 2'd0;
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= 32'h0;
            rf[2]      <= SP_INIT;
            rf[3]      <= GP_INIT;
        end else begin
            case (state)
                FETCH: if (mem_ack) begin
                    inst  <= mem_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    if (trap != 2'd0) begin
                        trap_cause <= trap;
                        halted     <= 1'b1;
                        state      <= HALT;
                    end else if (is_ld || is_st) begin
                        ea    <= addr_ea;
                        state <= MEM;
                    end else begin
                        if (wr && rd != 5'd0) rf[rd[AW-1:0]] <= res;
                        pc    <= npc;
                        state <= FETCH;
                    end
                end
                MEM: if (mem_ack) begin
                    if (is_ld && rd != 5'd0) rf[rd[AW-1:0]] <= ld_val;
                    pc    <= pc_plus4;
                    state <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule
